// File: rtl/fifo_rd_pkg.sv
// Shared types and sizes for the FIFO read controller.
// Includes the buffer-state encoding, the transfer-counter width and the default data width.
package fifo_rd_pkg;

  localparam int unsigned CNT_WIDTH          = 16;
  localparam int unsigned DEFAULT_DATA_WIDTH = 32;

  // Encoding equals the number of buffered words.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry output buffer with head/tail registers.
// Pushes enter at the tail and pops leave from the head, so words stay in order.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic [1:0]            o_occ
);

  buf_state_e            r_state;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (i_push) begin
            r_head  <= i_data;
            r_state <= ONE;
          end
        end
        ONE: begin
          case ({i_push, i_pop})
            2'b11: r_head <= i_data;
            2'b10: begin
              r_tail  <= i_data;
              r_state <= TWO;
            end
            2'b01: r_state <= EMPTY;
            default: ;
          endcase
        end
        TWO: begin
          // The controller never pushes into a full buffer unless a pop frees a slot.
          if (i_pop) begin
            r_head <= r_tail;
            if (i_push) r_tail  <= i_data;
            else        r_state <= ONE;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  assign o_data  = r_head;
  assign o_valid = (r_state != EMPTY);
  assign o_occ   = 2'(r_state);

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Reads a FIFO with one-cycle read latency and presents its words as a valid/ready stream.
// Defining FIFO_RD_CNT_EN adds the rd_count_o transfer counter.
module fifo_rd_ctrl
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  empty_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  rd_cs_o,
  output logic                  rd_en_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  rd_count_o
`endif
);

  logic       r_infl;
  logic [1:0] w_occ;
  logic [1:0] w_pending;
  logic       w_xfer;
  logic       w_rd;

  assign w_xfer    = out_valid_o && out_ready_i;
  assign w_pending = w_occ + {1'b0, r_infl};

  // Issue a read only when the word is guaranteed a buffer slot on arrival.
  assign w_rd    = !rst && !empty_i &&
                   ((w_pending < 2'd2) || ((w_pending == 2'd2) && w_xfer));
  assign rd_en_o = w_rd;
  assign rd_cs_o = w_rd;

  always_ff @(posedge clk) begin
    if (rst) r_infl <= 1'b0;
    else     r_infl <= w_rd;
  end

  fifo_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_infl),
    .i_data  (data_i),
    .i_pop   (w_xfer),
    .o_data  (out_data_o),
    .o_valid (out_valid_o),
    .o_occ   (w_occ)
  );

`ifdef FIFO_RD_CNT_EN
  logic [CNT_WIDTH-1:0] r_rd_count;

  always_ff @(posedge clk) begin
    if (rst)         r_rd_count <= '0;
    else if (w_xfer) r_rd_count <= r_rd_count + CNT_WIDTH'(1);
  end

  assign rd_count_o = r_rd_count;
`endif

endmodule
